bus_sequencer: RTL and testbench
================================

Name: bus_sequencer

Overview:
Parametrised external-memory bus sequencer for the 16-bit core. It replaces the hard-wired fetch/LDW/STW memory sub-states in the control FSM with one generic engine. The engine runs single or burst read/write cycles on the SysBus pads (ALE, nME, nOE, nWE, ENB), with configurable wait states, an external Ready extension and a timeout. The control FSM issues one request and waits for Done or Err.

Parameters:
DATA_W, 16, SysBus data width
ADDR_W, 16, word address width
WAIT_STATES, 1, fixed extra STROBE cycles per beat (0..15)
MAX_BURST, 4, maximum beats per request (1..16)
LEN_W, 3, width of ReqLen; must hold MAX_BURST
TIMEOUT, 32, max consecutive cycles Ready may stay low before abort (>=1)

Ports:
Clock  in  1  system clock, all state on rising edge
nReset  in  1  synchronous, active-low reset, sampled on rising Clock
Req  in  1  request strobe, only sampled in IDLE
ReqWrite  in  1  1=write, 0=read (fetch is a read)
ReqAddr  in  ADDR_W  first word address
ReqLen  in  LEN_W  beat count
WData  in  DATA_W  write data for current beat, sampled when WTake=1
Ready  in  1  memory ready; low extends STROBE
SysBusIn  in  DATA_W  data from pads
ReqAck  out  1  one-cycle pulse, request accepted
Busy  out  1  high from ADDR of beat 0 to end of last RECOV
WTake  out  1  pulse: WData consumed this cycle
RData  out  DATA_W  registered read data
RValid  out  1  one-cycle pulse per read beat
Done  out  1  one-cycle pulse, request completed OK
Err  out  1  one-cycle pulse, request aborted on timeout
SysBusOut  out  DATA_W  address (ADDR) or write data (STROBE/RECOV of write)
SysBusOe  out  1  pad output enable for SysBusOut
ALE, nME, nOE, nWE, ENB  out  1 each  pad controls (n* active low)

Behaviour:
- Reset (nReset=0 at edge): state IDLE. Next cycle and while held: ALE=0, nME=1, nOE=1, nWE=1, ENB=0, SysBusOe=0, SysBusOut=0, RData=0, ReqAck=Busy=WTake=RValid=Done=Err=0. Counters cleared. Reset mid-burst abandons the transfer silently, with no Done and no Err.
- IDLE: outputs at reset values. If Req=1: ReqAck=1 the same cycle; latch ReqWrite and ReqAddr; Len = ReqLen clamped to 1..MAX_BURST (0 counts as 1, >MAX_BURST counts as MAX_BURST); go to ADDR.
- ADDR (1 cycle): ALE=1, nME=0, SysBusOe=1, SysBusOut=current address. For writes, WTake=1 and WData is latched into the write register. Go to STROBE and load wait counter=WAIT_STATES and timeout counter=0.
- STROBE: nME=0.
  - Read: nOE=0, ENB=1, SysBusOe=0.
  - Write: nWE=0, SysBusOe=1, SysBusOut=write register.
  - Wait counter decrements each cycle to 0. Once it is 0, the cycle with Ready=1 is the final STROBE cycle. For reads, SysBusIn is captured into RData at that edge. Then go to RECOV.
  - While the counter is 0 and Ready=0, the timeout counter increments. When it reaches TIMEOUT, go to IDLE: Err=1 for one cycle, RValid is not asserted for that beat, and Done is not asserted.
  - Ready is ignored while the wait counter is nonzero.
- RECOV (1 cycle): nME=1, nOE=1, nWE=1, ENB=0. For writes, SysBusOe=1 and write data is held. For reads, RValid=1 with RData stable.
  - If beats remain: address = address+1, wrapping modulo 2^ADDR_W (0xFFFF -> 0x0000 at ADDR_W=16); go to ADDR.
  - Otherwise: Done=1 and go to IDLE. Busy drops the next cycle.
- Latency per beat = 3 + WAIT_STATES + Ready-low cycles.
- Req asserted while not in IDLE is ignored, with no queueing. A new Req can be accepted in the IDLE cycle immediately after Done.
- Done and Err are mutually exclusive.
- RData holds its last value until the next read capture.

Test Plan:
- Single read, WAIT_STATES=1, Ready=1, ReqAddr=0x0100, ReqLen=1, SysBusIn=0xBEEF in STROBE -> ReqAck at cycle 0; ALE at cycle 1 with SysBusOut=0x0100; nOE low at cycles 2-3; RValid and RData=0xBEEF at cycle 4; Done at cycle 4.
- Burst write of 4 beats at 0x0010, WData 0x1111/0x2222/0x3333/0x4444 -> four WTake pulses; addresses 0x0010..0x0013; nWE low with matching data each beat; Done once after beat 4; total 16 cycles.
- Ready held low for 3 cycles during a read -> STROBE extended by exactly 3 cycles; data captured on the first Ready=1 cycle; no Err.
- Ready held low for TIMEOUT=32 cycles -> Err pulse; no RValid for that beat; no Done; pads return to idle; next Req accepted normally.
- ReqAddr=0xFFFE with ReqLen=0 gives 1 beat; ReqAddr=0xFFFF with ReqLen=7 and MAX_BURST=4 gives 4 beats at addresses 0xFFFF, 0x0000, 0x0001, 0x0002.
- nReset=0 asserted during STROBE of beat 2 -> at the next edge all outputs take reset values, with no Done and no Err; Req issued after reset is released is accepted.

Source files
------------

// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
//   Generic external-memory bus engine for the 16-bit core. Runs single or
//   burst read/write cycles on the SysBus pads with configurable wait states,
//   a Ready-driven strobe extension and a Ready timeout. The control FSM
//   issues one request (Req) and waits for Done or Err.
//
// Ports
//   Clock, nReset        : clock, synchronous active-low reset
//   Req/ReqWrite/ReqAddr/ReqLen : request handshake, sampled only in IDLE
//   ReqAck               : one-cycle accept pulse
//   WData / WTake        : write data for the current beat, consumed on WTake
//   Ready                : memory ready, low extends STROBE
//   SysBusIn             : pad input data
//   RData / RValid       : registered read data, one RValid pulse per beat
//   Done / Err           : completion / timeout abort pulses
//   Busy                 : high from ADDR of first beat to end of last RECOV
//   SysBusOut/SysBusOe   : pad output data and its enable
//   ALE,nME,nOE,nWE,ENB  : pad strobes (n* active low)
//
// States
//   IDLE   | pads idle, waiting for Req
//   ADDR   | address phase, ALE high, write data latched
//   STROBE | data phase, wait states then Ready/timeout
//   RECOV  | recovery, RValid for reads, next beat or Done
// -----------------------------------------------------------------------------
module bus_sequencer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int MAX_BURST   = 4,
    parameter int LEN_W       = 3,
    parameter int TIMEOUT     = 32
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              Req,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [LEN_W-1:0]  ReqLen,
    input  logic [DATA_W-1:0] WData,
    input  logic              Ready,
    input  logic [DATA_W-1:0] SysBusIn,
    output logic              ReqAck,
    output logic              Busy,
    output logic              WTake,
    output logic [DATA_W-1:0] RData,
    output logic              RValid,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] SysBusOut,
    output logic              SysBusOe,
    output logic              ALE,
    output logic              nME,
    output logic              nOE,
    output logic              nWE,
    output logic              ENB
);

    localparam int WAIT_W = 4;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDR   = 2'd1,
        S_STROBE = 2'd2,
        S_RECOV  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    beats_q, beats_d;   // beats remaining after current
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [LEN_W-1:0]    len_clamped;

    // Zero length means one beat; anything above MAX_BURST is cut to MAX_BURST.
    always_comb begin
        len_clamped = ReqLen;
        if (ReqLen == '0) begin
            len_clamped = LEN_W'(1);
        end else if (ReqLen > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            beats_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wait_d    = wait_q;
        tmo_d     = tmo_q;

        ReqAck    = 1'b0;
        Busy      = 1'b0;
        WTake     = 1'b0;
        RValid    = 1'b0;
        Done      = 1'b0;
        Err       = 1'b0;
        SysBusOut = '0;
        SysBusOe  = 1'b0;
        ALE       = 1'b0;
        nME       = 1'b1;
        nOE       = 1'b1;
        nWE       = 1'b1;
        ENB       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    ReqAck  = 1'b1;
                    write_d = ReqWrite;
                    addr_d  = ReqAddr;
                    beats_d = len_clamped - LEN_W'(1);
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                Busy      = 1'b1;
                ALE       = 1'b1;
                nME       = 1'b0;
                SysBusOe  = 1'b1;
                SysBusOut = DATA_W'(addr_q);
                if (write_q) begin
                    WTake   = 1'b1;
                    wdata_d = WData;
                end
                wait_d  = WAIT_LOAD;
                tmo_d   = '0;
                state_d = S_STROBE;
            end

            S_STROBE: begin
                Busy = 1'b1;
                nME  = 1'b0;
                if (write_q) begin
                    nWE       = 1'b0;
                    SysBusOe  = 1'b1;
                    SysBusOut = wdata_q;
                end else begin
                    nOE = 1'b0;
                    ENB = 1'b1;
                end
                // Ready only matters once the fixed wait states have elapsed.
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else if (Ready) begin
                    if (!write_q) begin
                        rdata_d = SysBusIn;
                    end
                    state_d = S_RECOV;
                end else if (tmo_q == TMO_LAST) begin
                    // This is the TIMEOUT-th consecutive Ready-low cycle.
                    Err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_RECOV: begin
                Busy = 1'b1;
                if (write_q) begin
                    SysBusOe  = 1'b1;
                    SysBusOut = wdata_q;
                end else begin
                    RValid = 1'b1;
                end
                if (beats_q != '0) begin
                    beats_d = beats_q - LEN_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_ADDR;
                end else begin
                    Done    = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset arriving at this edge abandons the transfer: no handshake
        // pulse may escape in the cycle the reset is sampled.
        if (!nReset) begin
            ReqAck = 1'b0;
            WTake  = 1'b0;
            RValid = 1'b0;
            Done   = 1'b0;
            Err    = 1'b0;
        end
    end

    assign RData = rdata_q;

endmodule

// File: tb/tb_bus_sequencer.sv
module tb_bus_sequencer;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        Req;
    logic        ReqWrite;
    logic [15:0] ReqAddr;
    logic [2:0]  ReqLen;
    logic [15:0] WData;
    logic        Ready;
    logic [15:0] SysBusIn;
    logic        ReqAck, Busy, WTake, RValid, Done, Err;
    logic [15:0] RData, SysBusOut;
    logic        SysBusOe, ALE, nME, nOE, nWE, ENB;

    int compared = 0;
    int mismatched = 0;

    // pads = {ALE,nME,nOE,nWE,ENB,SysBusOe}
    localparam logic [5:0] P_IDLE = 6'b011100;
    localparam logic [5:0] P_ADDR = 6'b101101;
    localparam logic [5:0] P_SRD  = 6'b000110;
    localparam logic [5:0] P_SWR  = 6'b001001;
    localparam logic [5:0] P_RRD  = 6'b011100;
    localparam logic [5:0] P_RWR  = 6'b011101;
    // status = {ReqAck,Busy,WTake,RValid,Done,Err}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_ACK  = 6'b100000;
    localparam logic [5:0] S_BUSY = 6'b010000;
    localparam logic [5:0] S_WTK  = 6'b011000;
    localparam logic [5:0] S_RV   = 6'b010100;
    localparam logic [5:0] S_RVD  = 6'b010110;
    localparam logic [5:0] S_WD   = 6'b010010;
    localparam logic [5:0] S_ERR  = 6'b010001;

    bus_sequencer #(
        .DATA_W(16), .ADDR_W(16), .WAIT_STATES(1),
        .MAX_BURST(4), .LEN_W(3), .TIMEOUT(32)
    ) dut (
        .Clock(Clock), .nReset(nReset), .Req(Req), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqLen(ReqLen), .WData(WData), .Ready(Ready),
        .SysBusIn(SysBusIn), .ReqAck(ReqAck), .Busy(Busy), .WTake(WTake),
        .RData(RData), .RValid(RValid), .Done(Done), .Err(Err),
        .SysBusOut(SysBusOut), .SysBusOe(SysBusOe), .ALE(ALE), .nME(nME),
        .nOE(nOE), .nWE(nWE), .ENB(ENB)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] pads();
        return {10'b0, ALE, nME, nOE, nWE, ENB, SysBusOe};
    endfunction

    function automatic logic [15:0] stat();
        return {10'b0, ReqAck, Busy, WTake, RValid, Done, Err};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input logic wr, input logic [15:0] a, input logic [2:0] len);
        Req = 1'b1; ReqWrite = wr; ReqAddr = a; ReqLen = len;
    endtask

    // One read beat with Ready=1: ADDR, two STROBE cycles, RECOV.
    task automatic rd_beat(input logic [15:0] a, input logic [15:0] d, input logic last);
        tick(); Req = 1'b0; Ready = 1'b1; SysBusIn = d; settle();
        chk("rd_addr_pads", pads(), {10'b0, P_ADDR});
        chk("rd_addr_bus", SysBusOut, a);
        chk("rd_addr_stat", stat(), {10'b0, S_BUSY});
        tick(); settle();
        chk("rd_strb1_pads", pads(), {10'b0, P_SRD});
        chk("rd_strb1_bus", SysBusOut, 16'h0000);
        tick(); settle();
        chk("rd_strb2_pads", pads(), {10'b0, P_SRD});
        chk("rd_strb2_stat", stat(), {10'b0, S_BUSY});
        tick(); SysBusIn = 16'hFFFF; settle();
        chk("rd_recov_pads", pads(), {10'b0, P_RRD});
        chk("rd_recov_stat", stat(), {10'b0, last ? S_RVD : S_RV});
        chk("rd_recov_data", RData, d);
    endtask

    // One write beat with Ready=1; WData is scrambled after ADDR to prove it was latched.
    task automatic wr_beat(input logic [15:0] a, input logic [15:0] d, input logic last);
        tick(); Req = 1'b0; Ready = 1'b1; WData = d; settle();
        chk("wr_addr_pads", pads(), {10'b0, P_ADDR});
        chk("wr_addr_bus", SysBusOut, a);
        chk("wr_addr_stat", stat(), {10'b0, S_WTK});
        tick(); WData = 16'hDEAD; settle();
        chk("wr_strb1_pads", pads(), {10'b0, P_SWR});
        chk("wr_strb1_bus", SysBusOut, d);
        tick(); settle();
        chk("wr_strb2_pads", pads(), {10'b0, P_SWR});
        chk("wr_strb2_stat", stat(), {10'b0, S_BUSY});
        tick(); settle();
        chk("wr_recov_pads", pads(), {10'b0, P_RWR});
        chk("wr_recov_bus", SysBusOut, d);
        chk("wr_recov_stat", stat(), {10'b0, last ? S_WD : S_BUSY});
    endtask

    initial begin
        logic [15:0] wd [4];
        logic [15:0] a;
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;

        nReset = 1'b0; Req = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqLen = '0;
        WData = '0; Ready = 1'b1; SysBusIn = '0;
        tick(); tick();
        Req = 1'b1; settle();
        chk("rst_pads", pads(), {10'b0, P_IDLE});
        chk("rst_stat", stat(), {10'b0, S_NONE});
        chk("rst_bus", SysBusOut, 16'h0000);
        chk("rst_rdata", RData, 16'h0000);

        // Single read at 0x0100
        tick(); nReset = 1'b1; req(1'b0, 16'h0100, 3'd1); settle();
        chk("t1_ack", stat(), {10'b0, S_ACK});
        rd_beat(16'h0100, 16'hBEEF, 1'b1);
        tick(); settle();
        chk("t1_idle_stat", stat(), {10'b0, S_NONE});
        chk("t1_idle_pads", pads(), {10'b0, P_IDLE});
        chk("t1_rdata_hold", RData, 16'hBEEF);

        // Burst write of 4 beats at 0x0010
        tick(); req(1'b1, 16'h0010, 3'd4); settle();
        chk("t2_ack", stat(), {10'b0, S_ACK});
        for (int b = 0; b < 4; b++) begin
            wr_beat(16'h0010 + 16'(b), wd[b], b == 3);
        end
        tick(); settle();
        chk("t2_idle_after16", stat(), {10'b0, S_NONE});

        // Read with Ready low for 3 cycles after the wait state
        tick(); req(1'b0, 16'h0200, 3'd1); settle();
        chk("t3_ack", stat(), {10'b0, S_ACK});
        tick(); Req = 1'b0; Ready = 1'b0; SysBusIn = 16'h1234; settle();
        chk("t3_addr_bus", SysBusOut, 16'h0200);
        tick(); settle();
        chk("t3_strb_wait", pads(), {10'b0, P_SRD});
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("t3_ext_pads", pads(), {10'b0, P_SRD});
            chk("t3_ext_stat", stat(), {10'b0, S_BUSY});
        end
        tick(); Ready = 1'b1; SysBusIn = 16'h5678; settle();
        chk("t3_final_strb", pads(), {10'b0, P_SRD});
        tick(); SysBusIn = 16'h0000; settle();
        chk("t3_recov_stat", stat(), {10'b0, S_RVD});
        chk("t3_rdata", RData, 16'h5678);
        tick(); settle();
        chk("t3_idle", stat(), {10'b0, S_NONE});

        // Timeout: Ready held low
        tick(); req(1'b0, 16'h0300, 3'd1); Ready = 1'b0; SysBusIn = 16'h9999; settle();
        chk("t4_ack", stat(), {10'b0, S_ACK});
        tick(); Req = 1'b0; settle();
        chk("t4_addr", pads(), {10'b0, P_ADDR});
        for (int i = 0; i < 32; i++) begin
            tick(); settle();
            chk("t4_wait_stat", stat(), {10'b0, S_BUSY});
        end
        tick(); settle();
        chk("t4_err_stat", stat(), {10'b0, S_ERR});
        chk("t4_err_pads", pads(), {10'b0, P_SRD});
        tick(); Ready = 1'b1; req(1'b0, 16'hFFFE, 3'd0); settle();
        chk("t4_idle_pads", pads(), {10'b0, P_IDLE});
        chk("t4_next_ack", stat(), {10'b0, S_ACK});
        chk("t4_rdata_kept", RData, 16'h5678);

        // Length clamps and address wrap
        rd_beat(16'hFFFE, 16'hA5A5, 1'b1);
        tick(); req(1'b1, 16'hFFFF, 3'd7); settle();
        chk("t5_ack_after_done", stat(), {10'b0, S_ACK});
        a = 16'hFFFF;
        for (int b = 0; b < 4; b++) begin
            wr_beat(a, wd[3-b], b == 3);
            a = a + 16'd1;
        end
        tick(); settle();
        chk("t5_idle", stat(), {10'b0, S_NONE});

        // Reset during STROBE of beat 2
        tick(); req(1'b0, 16'h0400, 3'd2); settle();
        chk("t6_ack", stat(), {10'b0, S_ACK});
        rd_beat(16'h0400, 16'h7777, 1'b0);
        tick(); settle();
        chk("t6_addr2", SysBusOut, 16'h0401);
        tick(); nReset = 1'b0; settle();
        chk("t6_strb_stat", stat(), {10'b0, S_BUSY});
        tick(); settle();
        chk("t6_rst_pads", pads(), {10'b0, P_IDLE});
        chk("t6_rst_stat", stat(), {10'b0, S_NONE});
        chk("t6_rst_bus", SysBusOut, 16'h0000);
        chk("t6_rst_rdata", RData, 16'h0000);
        tick(); nReset = 1'b1; req(1'b0, 16'h0500, 3'd1); settle();
        chk("t6_ack_after_rst", stat(), {10'b0, S_ACK});
        rd_beat(16'h0500, 16'h0A0A, 1'b1);
        tick(); settle();
        chk("t6_idle", stat(), {10'b0, S_NONE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
